// File: rtl/u62_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : u62_pkg                                                |
// | Description : Shared command codes and FSM state encoding for the    |
// |               CDTV front-panel (U62) serial link responder.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package u62_pkg;

  // Front-panel command byte codes sent by U62
  localparam logic [7:0] CMD_PLAY_CODE   = 8'h80;
  localparam logic [7:0] CMD_STOP_CODE   = 8'h60;
  localparam logic [7:0] CMD_REWIND_CODE = 8'h20;
  localparam logic [7:0] CMD_FF_CODE     = 8'h40;
  localparam logic [7:0] CMD_IDLE_CODE   = 8'h08;

  // Link FSM states: receive command, wait for turnaround fall, send status
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RX   = 2'd1,
    ST_TURN = 2'd2,
    ST_TX   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/u62_serial_port_sync_edge_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sync_edge_detect                                       |
// | Description : Multi-flop synchroniser for an asynchronous input with |
// |               single-cycle rise/fall pulses from the synced copy.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module sync_edge_detect #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_din,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;

  // Synchroniser chain plus one extra delayed copy for edge comparison
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_dly  <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
      r_dly  <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_dly;
  assign o_fall = ~r_sync[SYNC_STAGES-1] & r_dly;

endmodule
`default_nettype wire

// File: rtl/u62_serial_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : u62_serial_port                                        |
// | Description : Drive-side responder for the U62 front-panel serial    |
// |               link: receives a command byte, returns a status byte,  |
// |               and decodes commands into one-cycle pulses.            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module u62_serial_port
  import u62_pkg::*;
#(
  parameter int         SYNC_STAGES    = 2,
  parameter int         TIMEOUT_CYCLES = 200000,
  parameter logic [7:0] PLAY_CODE      = CMD_PLAY_CODE,
  parameter logic [7:0] STOP_CODE      = CMD_STOP_CODE,
  parameter logic [7:0] REWIND_CODE    = CMD_REWIND_CODE,
  parameter logic [7:0] FF_CODE        = CMD_FF_CODE,
  parameter logic [7:0] IDLE_CODE      = CMD_IDLE_CODE
) (
  input  logic       PI_CLK,
  input  logic       RESET_n,
  input  logic       SCK,
  input  logic       SDATA_IN,
  output logic       SDATA_OUT,
  output logic       SDATA_OE,
  input  logic [7:0] FP_STATUS,
  output logic [7:0] FP_COMMAND,
  output logic       CMD_VALID,
  output logic       CMD_PLAY,
  output logic       CMD_STOP,
  output logic       CMD_REWIND,
  output logic       CMD_FF,
  output logic       CMD_IDLE,
  output logic       CMD_UNKNOWN,
  output logic       FRAME_ERROR,
  output logic       BUSY
);

  localparam int c_TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

  // Synchronised SCK edges and SDATA sample
  logic                   w_sck_rise;
  logic                   w_sck_fall;
  logic [SYNC_STAGES-1:0] r_sdata_sync;
  logic                   w_sdata;

  // FSM / datapath registers
  state_t                 r_state;
  logic [3:0]             r_bit_cnt;
  logic [7:0]             r_rx_shift;
  logic [7:0]             r_tx_shift;
  logic                   r_oe;
  logic                   r_out;
  logic [c_TO_W-1:0]      r_to_cnt;

  // Next-state values
  state_t                 w_state_nxt;
  logic [3:0]             w_bit_nxt;
  logic [7:0]             w_rx_nxt;
  logic [7:0]             w_tx_nxt;
  logic                   w_oe_nxt;
  logic                   w_out_nxt;
  logic [c_TO_W-1:0]      w_to_nxt;
  logic                   w_timeout;
  logic                   w_cmd_load;
  logic                   w_frame_err;

  // Registered command outputs
  logic [7:0]             r_fp_command;
  logic                   r_cmd_valid;
  logic                   r_cmd_play;
  logic                   r_cmd_stop;
  logic                   r_cmd_rewind;
  logic                   r_cmd_ff;
  logic                   r_cmd_idle;
  logic                   r_cmd_unknown;
  logic                   r_frame_error;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b1)
  ) u_sck_sync (
    .clk    (PI_CLK),
    .rst_n  (RESET_n),
    .i_din  (SCK),
    .o_rise (w_sck_rise),
    .o_fall (w_sck_fall)
  );

  // SDATA synchroniser; same depth as SCK so data lines up with the edge pulse
  always_ff @(posedge PI_CLK) begin
    if (!RESET_n) begin
      r_sdata_sync <= {SYNC_STAGES{1'b1}};
    end else begin
      r_sdata_sync <= {r_sdata_sync[SYNC_STAGES-2:0], SDATA_IN};
    end
  end

  assign w_sdata = r_sdata_sync[SYNC_STAGES-1];

  // FSM state and shift/counter registers
  always_ff @(posedge PI_CLK) begin
    if (!RESET_n) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= 4'd0;
      r_rx_shift <= 8'h00;
      r_tx_shift <= 8'h00;
      r_oe       <= 1'b0;
      r_out      <= 1'b0;
      r_to_cnt   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_rx_shift <= w_rx_nxt;
      r_tx_shift <= w_tx_nxt;
      r_oe       <= w_oe_nxt;
      r_out      <= w_out_nxt;
      r_to_cnt   <= w_to_nxt;
    end
  end

  // Next-state logic: bit sequencing, status shifting and timeout abort
  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit_cnt;
    w_rx_nxt    = r_rx_shift;
    w_tx_nxt    = r_tx_shift;
    w_oe_nxt    = r_oe;
    w_out_nxt   = r_out;
    w_cmd_load  = 1'b0;
    w_frame_err = 1'b0;
    w_to_nxt    = r_to_cnt + 1'b1;
    // Any SCK edge in the terminal cycle wins over the abort
    w_timeout   = (r_to_cnt == c_TO_LAST) && !w_sck_rise && !w_sck_fall;

    if (w_sck_rise || w_sck_fall) begin
      w_to_nxt = '0;
    end

    case (r_state)
      ST_IDLE: begin
        w_to_nxt = '0;
        if (w_sck_fall) begin
          w_state_nxt = ST_RX;
          w_bit_nxt   = 4'd0;
        end
      end
      ST_RX: begin
        if (w_sck_rise) begin
          w_rx_nxt = {r_rx_shift[6:0], w_sdata};
          if (r_bit_cnt == 4'd7) begin
            w_cmd_load  = 1'b1;
            w_tx_nxt    = FP_STATUS;
            w_state_nxt = ST_TURN;
            w_bit_nxt   = 4'd8;
          end else begin
            w_bit_nxt = r_bit_cnt + 4'd1;
          end
        end
      end
      ST_TURN: begin
        if (w_sck_fall) begin
          w_oe_nxt    = 1'b1;
          w_out_nxt   = r_tx_shift[7];
          w_bit_nxt   = 4'd0;
          w_state_nxt = ST_TX;
        end
      end
      ST_TX: begin
        if (w_sck_rise) begin
          if (r_bit_cnt < 4'd8) begin
            w_bit_nxt = r_bit_cnt + 4'd1;
          end
        end else if (w_sck_fall) begin
          if (r_bit_cnt < 4'd8) begin
            w_tx_nxt  = {r_tx_shift[6:0], 1'b0};
            w_out_nxt = r_tx_shift[6];
          end else begin
            // Status byte done; this fall starts the next command byte
            w_oe_nxt    = 1'b0;
            w_out_nxt   = 1'b0;
            w_bit_nxt   = 4'd0;
            w_state_nxt = ST_RX;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if ((r_state != ST_IDLE) && w_timeout) begin
      // A quiet link right after a status byte is a normal end, not an error
      w_frame_err = !((r_state == ST_RX) && (r_bit_cnt == 4'd0));
      w_state_nxt = ST_IDLE;
      w_bit_nxt   = 4'd0;
      w_rx_nxt    = 8'h00;
      w_oe_nxt    = 1'b0;
      w_out_nxt   = 1'b0;
      w_to_nxt    = '0;
    end
  end

  // Command capture and decode pulses, one cycle after the 8th bit
  always_ff @(posedge PI_CLK) begin
    if (!RESET_n) begin
      r_fp_command  <= 8'h00;
      r_cmd_valid   <= 1'b0;
      r_cmd_play    <= 1'b0;
      r_cmd_stop    <= 1'b0;
      r_cmd_rewind  <= 1'b0;
      r_cmd_ff      <= 1'b0;
      r_cmd_idle    <= 1'b0;
      r_cmd_unknown <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_cmd_valid   <= w_cmd_load;
      r_cmd_play    <= w_cmd_load && (w_rx_nxt == PLAY_CODE);
      r_cmd_stop    <= w_cmd_load && (w_rx_nxt == STOP_CODE);
      r_cmd_rewind  <= w_cmd_load && (w_rx_nxt == REWIND_CODE);
      r_cmd_ff      <= w_cmd_load && (w_rx_nxt == FF_CODE);
      r_cmd_idle    <= w_cmd_load && (w_rx_nxt == IDLE_CODE);
      r_cmd_unknown <= w_cmd_load && (w_rx_nxt != PLAY_CODE) &&
                       (w_rx_nxt != STOP_CODE) && (w_rx_nxt != REWIND_CODE) &&
                       (w_rx_nxt != FF_CODE) && (w_rx_nxt != IDLE_CODE);
      r_frame_error <= w_frame_err;
      if (w_cmd_load) begin
        r_fp_command <= w_rx_nxt;
      end
    end
  end

  assign SDATA_OUT   = r_out;
  assign SDATA_OE    = r_oe;
  assign FP_COMMAND  = r_fp_command;
  assign CMD_VALID   = r_cmd_valid;
  assign CMD_PLAY    = r_cmd_play;
  assign CMD_STOP    = r_cmd_stop;
  assign CMD_REWIND  = r_cmd_rewind;
  assign CMD_FF      = r_cmd_ff;
  assign CMD_IDLE    = r_cmd_idle;
  assign CMD_UNKNOWN = r_cmd_unknown;
  assign FRAME_ERROR = r_frame_error;
  assign BUSY        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_u62_serial_port.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module      : tb_u62_serial_port                                     |
// | Description : Directed self-checking bench for u62_serial_port,      |
// |               acting as the U62 initiator on SCK/SDATA.              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_u62_serial_port;

  localparam int H  = 8;    // SCK half period in PI_CLK cycles
  localparam int TO = 200;  // shortened timeout for simulation

  logic       PI_CLK    = 1'b0;
  logic       RESET_n   = 1'b0;
  logic       SCK       = 1'b1;
  logic       SDATA_IN  = 1'b1;
  logic [7:0] FP_STATUS = 8'h00;
  logic       SDATA_OUT, SDATA_OE, CMD_VALID, CMD_PLAY, CMD_STOP, CMD_REWIND;
  logic       CMD_FF, CMD_IDLE, CMD_UNKNOWN, FRAME_ERROR, BUSY;
  logic [7:0] FP_COMMAND;

  int checks   = 0;
  int failures = 0;

  // Pulse counters maintained by the monitor; tests work on differences
  int n_valid = 0, n_play = 0, n_stop = 0, n_rew = 0, n_ff = 0;
  int n_idle = 0, n_unk = 0, n_ferr = 0, n_excl = 0;
  int s_valid, s_play, s_stop, s_rew, s_ff, s_idle, s_unk, s_ferr, s_excl;

  u62_serial_port #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .PI_CLK      (PI_CLK),
    .RESET_n     (RESET_n),
    .SCK         (SCK),
    .SDATA_IN    (SDATA_IN),
    .SDATA_OUT   (SDATA_OUT),
    .SDATA_OE    (SDATA_OE),
    .FP_STATUS   (FP_STATUS),
    .FP_COMMAND  (FP_COMMAND),
    .CMD_VALID   (CMD_VALID),
    .CMD_PLAY    (CMD_PLAY),
    .CMD_STOP    (CMD_STOP),
    .CMD_REWIND  (CMD_REWIND),
    .CMD_FF      (CMD_FF),
    .CMD_IDLE    (CMD_IDLE),
    .CMD_UNKNOWN (CMD_UNKNOWN),
    .FRAME_ERROR (FRAME_ERROR),
    .BUSY        (BUSY)
  );

  always #5 PI_CLK = ~PI_CLK;

  // Count output pulses, sampled on the inactive edge
  always @(negedge PI_CLK) begin
    if (CMD_VALID)   n_valid++;
    if (CMD_PLAY)    n_play++;
    if (CMD_STOP)    n_stop++;
    if (CMD_REWIND)  n_rew++;
    if (CMD_FF)      n_ff++;
    if (CMD_IDLE)    n_idle++;
    if (CMD_UNKNOWN) n_unk++;
    if (FRAME_ERROR) n_ferr++;
    if ($countones({CMD_PLAY, CMD_STOP, CMD_REWIND, CMD_FF, CMD_IDLE, CMD_UNKNOWN})
        != (CMD_VALID ? 1 : 0)) n_excl++;
  end

  task automatic clks(input int n);
    repeat (n) @(negedge PI_CLK);
  endtask

  task automatic snap();
    s_valid = n_valid; s_play = n_play; s_stop = n_stop; s_rew = n_rew;
    s_ff = n_ff; s_idle = n_idle; s_unk = n_unk; s_ferr = n_ferr; s_excl = n_excl;
  endtask

  // U62 sends command bits: data changes on fall, held across rise
  task automatic send_cmd(input logic [7:0] c, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      SCK = 1'b0;
      SDATA_IN = c[7-i];
      clks(H);
      SCK = 1'b1;
      clks(H);
    end
  endtask

  // U62 clocks status bits, sampling SDATA_OUT as it raises SCK
  task automatic read_bits(input int nbits, input int chg_at, input logic [7:0] chg_val,
                           output logic [7:0] st);
    st = 8'h00;
    SDATA_IN = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      if (i == chg_at) FP_STATUS = chg_val;
      SCK = 1'b0;
      clks(H);
      st[7-i] = SDATA_OUT;
      SCK = 1'b1;
      clks(H);
    end
  endtask

  // Hold SCK low past the timeout so the link drops to IDLE, then park high
  task automatic idle_out();
    clks(TO + 20);
    SCK = 1'b1;
    clks(H);
  endtask

  task automatic test_reset();
    RESET_n = 1'b0;
    SCK = 1'b0;
    for (int i = 0; i < 6; i++) begin
      SDATA_IN = ~SDATA_IN;
      clks(1);
    end
    checks++;
    if ({SDATA_OUT, SDATA_OE, CMD_VALID, CMD_PLAY, CMD_STOP, CMD_REWIND, CMD_FF,
         CMD_IDLE, CMD_UNKNOWN, FRAME_ERROR, BUSY} !== 11'b0) begin
      failures++;
      $display("FAIL reset_outputs actual=%b expected=%b",
               {SDATA_OUT, SDATA_OE, CMD_VALID, CMD_PLAY, CMD_STOP, CMD_REWIND, CMD_FF,
                CMD_IDLE, CMD_UNKNOWN, FRAME_ERROR, BUSY}, 11'b0);
    end
    checks++;
    if (FP_COMMAND !== 8'h00) begin
      failures++;
      $display("FAIL reset_fp_command actual=%h expected=00", FP_COMMAND);
    end
    SCK = 1'b1;
    SDATA_IN = 1'b1;
    clks(2);
    RESET_n = 1'b1;
    clks(10);
    checks++;
    if (BUSY !== 1'b0 || SDATA_OE !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle actual busy=%b oe=%b expected busy=0 oe=0", BUSY, SDATA_OE);
    end
  endtask

  task automatic test_play();
    logic [7:0] st;
    logic [7:0] exp_st;
    exp_st = 8'hA5;
    FP_STATUS = 8'hA5;
    snap();
    send_cmd(8'h80, 8);
    checks++;
    if (n_valid - s_valid != 1 || n_play - s_play != 1 || n_unk - s_unk != 0) begin
      failures++;
      $display("FAIL play_pulses actual valid=%0d play=%0d unk=%0d expected 1 1 0",
               n_valid - s_valid, n_play - s_play, n_unk - s_unk);
    end
    checks++;
    if (FP_COMMAND !== 8'h80) begin
      failures++;
      $display("FAIL play_fp_command actual=%h expected=80", FP_COMMAND);
    end
    read_bits(8, -1, 8'h00, st);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (st[7-i] !== exp_st[7-i]) begin
        failures++;
        $display("FAIL play_bit%0d actual=%b expected=%b", i, st[7-i], exp_st[7-i]);
      end
    end
    checks++;
    if (SDATA_OE !== 1'b1) begin
      failures++;
      $display("FAIL play_oe_last_bit actual=%b expected=1", SDATA_OE);
    end
    SCK = 1'b0;
    clks(H);
    checks++;
    if (SDATA_OE !== 1'b0 || BUSY !== 1'b1) begin
      failures++;
      $display("FAIL play_oe_release actual oe=%b busy=%b expected oe=0 busy=1", SDATA_OE, BUSY);
    end
    idle_out();
    checks++;
    if (BUSY !== 1'b0 || n_ferr - s_ferr != 0) begin
      failures++;
      $display("FAIL play_quiet_end actual busy=%b ferr=%0d expected busy=0 ferr=0",
               BUSY, n_ferr - s_ferr);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] st1, st2;
    FP_STATUS = 8'h3C;
    snap();
    send_cmd(8'h40, 8);
    read_bits(8, -1, 8'h00, st1);
    send_cmd(8'h55, 8);
    read_bits(8, -1, 8'h00, st2);
    SCK = 1'b0;
    clks(H);
    idle_out();
    checks++;
    if (n_ff - s_ff != 1 || n_unk - s_unk != 1 || n_valid - s_valid != 2) begin
      failures++;
      $display("FAIL b2b_pulses actual ff=%0d unk=%0d valid=%0d expected 1 1 2",
               n_ff - s_ff, n_unk - s_unk, n_valid - s_valid);
    end
    checks++;
    if (FP_COMMAND !== 8'h55) begin
      failures++;
      $display("FAIL b2b_fp_command actual=%h expected=55", FP_COMMAND);
    end
    checks++;
    if (n_ferr - s_ferr != 0) begin
      failures++;
      $display("FAIL b2b_frame_error actual=%0d expected=0", n_ferr - s_ferr);
    end
    checks++;
    if (st1 !== 8'h3C || st2 !== 8'h3C) begin
      failures++;
      $display("FAIL b2b_status actual=%h/%h expected=3c/3c", st1, st2);
    end
    checks++;
    if (n_excl - s_excl != 0) begin
      failures++;
      $display("FAIL b2b_decode_onehot actual=%0d expected=0", n_excl - s_excl);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] st;
    snap();
    send_cmd(8'hA8, 5);
    clks(TO + 10);
    checks++;
    if (n_ferr - s_ferr != 1) begin
      failures++;
      $display("FAIL timeout_frame_error actual=%0d expected=1", n_ferr - s_ferr);
    end
    checks++;
    if (FP_COMMAND !== 8'h55 || n_valid - s_valid != 0) begin
      failures++;
      $display("FAIL timeout_cmd_kept actual=%h valid=%0d expected=55 valid=0",
               FP_COMMAND, n_valid - s_valid);
    end
    checks++;
    if (BUSY !== 1'b0 || SDATA_OE !== 1'b0) begin
      failures++;
      $display("FAIL timeout_idle actual busy=%b oe=%b expected busy=0 oe=0", BUSY, SDATA_OE);
    end
    snap();
    send_cmd(8'h60, 8);
    read_bits(8, -1, 8'h00, st);
    SCK = 1'b0;
    clks(H);
    idle_out();
    checks++;
    if (n_stop - s_stop != 1 || n_valid - s_valid != 1 || FP_COMMAND !== 8'h60) begin
      failures++;
      $display("FAIL timeout_recover_stop actual stop=%0d valid=%0d cmd=%h expected 1 1 60",
               n_stop - s_stop, n_valid - s_valid, FP_COMMAND);
    end
  endtask

  task automatic test_status_hold();
    logic [7:0] st;
    FP_STATUS = 8'h0F;
    snap();
    send_cmd(8'h20, 8);
    read_bits(8, 3, 8'hF0, st);
    SCK = 1'b0;
    clks(H);
    idle_out();
    checks++;
    if (st !== 8'h0F) begin
      failures++;
      $display("FAIL status_hold actual=%h expected=0f", st);
    end
    checks++;
    if (n_rew - s_rew != 1) begin
      failures++;
      $display("FAIL status_hold_rewind actual=%0d expected=1", n_rew - s_rew);
    end
  endtask

  task automatic test_reset_mid_tx();
    logic [7:0] st;
    FP_STATUS = 8'hC3;
    send_cmd(8'h80, 8);
    read_bits(3, -1, 8'h00, st);
    SCK = 1'b0;
    clks(H / 2);
    checks++;
    if (SDATA_OE !== 1'b1) begin
      failures++;
      $display("FAIL midtx_oe_before_reset actual=%b expected=1", SDATA_OE);
    end
    RESET_n = 1'b0;
    @(posedge PI_CLK);
    @(negedge PI_CLK);
    checks++;
    if (SDATA_OE !== 1'b0 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL midtx_reset actual oe=%b busy=%b expected oe=0 busy=0", SDATA_OE, BUSY);
    end
    SCK = 1'b1;
    clks(3);
    RESET_n = 1'b1;
    clks(H);
    checks++;
    if (FP_COMMAND !== 8'h00 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL midtx_after_reset actual cmd=%h busy=%b expected cmd=00 busy=0",
               FP_COMMAND, BUSY);
    end
    snap();
    send_cmd(8'h08, 8);
    read_bits(8, -1, 8'h00, st);
    SCK = 1'b0;
    clks(H);
    idle_out();
    checks++;
    if (n_idle - s_idle != 1 || FP_COMMAND !== 8'h08) begin
      failures++;
      $display("FAIL midtx_idle_cmd actual idle=%0d cmd=%h expected 1 08",
               n_idle - s_idle, FP_COMMAND);
    end
    checks++;
    if (st !== 8'hC3) begin
      failures++;
      $display("FAIL midtx_status actual=%h expected=c3", st);
    end
  endtask

  initial begin
    test_reset();
    test_play();
    test_back_to_back();
    test_timeout();
    test_status_hold();
    test_reset_mid_tx();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/u62_serial_port.md
Name: u62_serial_port

Overview:
- Drive-side responder for the bit-serial link to the CDTV front-panel controller U62.
- U62 is the initiator and supplies SCK. Each transaction is one command byte from U62, then one status byte from the drive, on the shared SDATA line.
- Runs on PI_CLK. Decodes front-panel commands into one-cycle pulses for the drive logic.
- Presents FP_STATUS back to U62. The top level owns the SDATA tristate, built from SDATA_OUT and SDATA_OE.

Parameters:
- SYNC_STAGES, 2, synchroniser depth for SCK and SDATA_IN; minimum 2.
- TIMEOUT_CYCLES, 200000, PI_CLK cycles with no SCK edge mid-transaction before abort (1 ms at 200 MHz).
- CMD_PLAY, 8'h80, play command code.
- CMD_STOP, 8'h60, stop command code.
- CMD_REWIND, 8'h20, rewind command code.
- CMD_FF, 8'h40, fast-forward command code.
- CMD_IDLE, 8'h08, idle/no-key command code.

Ports:
- PI_CLK  in  1  system clock, 200 MHz.
- RESET_n  in  1  reset; one clock, reset is synchronous and active-low.
- SCK  in  1  serial clock from U62; asynchronous; idles high.
- SDATA_IN  in  1  SDATA pin input; asynchronous.
- SDATA_OUT  out  1  value to drive on SDATA.
- SDATA_OE  out  1  1 = drive SDATA, 0 = high-Z.
- FP_STATUS  in  8  status byte to return to U62.
- FP_COMMAND  out  8  last complete command byte; held until the next one.
- CMD_VALID  out  1  one-cycle pulse when FP_COMMAND updates.
- CMD_PLAY, CMD_STOP, CMD_REWIND, CMD_FF, CMD_IDLE  out  1 each  one-cycle decoded pulses, coincident with CMD_VALID.
- CMD_UNKNOWN  out  1  pulse with CMD_VALID when the byte matches no code.
- FRAME_ERROR  out  1  one-cycle pulse on timeout abort.
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset (RESET_n low at a PI_CLK rising edge):
  - All outputs go to 0 except FP_COMMAND, which goes to 8'h00.
  - State = IDLE, bit counter = 0, shift registers = 0.
  - Synchroniser flops reset to 1 (line idle level).
  - Reset mid-transaction releases SDATA_OE on the next edge.
- Edge detect:
  - SCK and SDATA_IN pass through SYNC_STAGES flops.
  - sck_rise/sck_fall come from the last synchronised stage vs one more delayed copy.
  - An edge is recognised SYNC_STAGES+1 cycles after the pin transition.
- Bit order and timing: MSB first in both directions.
  - U62 changes data on SCK fall and samples on SCK rise.
  - The block samples on sck_rise and changes SDATA_OUT on sck_fall.
- FSM states IDLE, RX, TURN, TX:
  - IDLE: first sck_fall → RX, bit counter 0.
  - RX: on each sck_rise, shift the synchronised SDATA into rx_shift and increment the counter.
    - On the 8th rise: FP_COMMAND <= assembled byte; pulse CMD_VALID and the decode next cycle (latency 1 from the 8th sck_rise detect).
    - Same cycle: latch FP_STATUS into tx_shift; state → TURN.
  - TURN: next sck_fall → SDATA_OE=1, SDATA_OUT=tx_shift[7], counter 0, state → TX.
  - TX: on sck_rise, increment the counter. On sck_fall with counter<8, shift left and drive the next bit.
    - On the sck_fall after the 8th sck_rise, SDATA_OE=0 and state → RX.
    - This makes back-to-back transactions legal; that fall begins the next command byte.
- FP_STATUS changes after the TURN latch do not affect the byte in flight.
- Decode:
  - Exact 8-bit compare against the CMD_* parameters.
  - Exactly one of the five decode pulses or CMD_UNKNOWN fires per CMD_VALID.
- Timeout:
  - Counter clears on any SCK edge and on entry to IDLE; it counts in RX/TURN/TX.
  - At TIMEOUT_CYCLES-1: pulse FRAME_ERROR, SDATA_OE=0, state → IDLE.
  - A partial command byte is discarded and FP_COMMAND is unchanged.
  - A timeout in RX with counter=0 (quiet link between transactions) returns to IDLE without FRAME_ERROR.
- Simultaneous events:
  - An sck_rise and sck_fall in the same cycle cannot occur, because the synchroniser delivers one edge per cycle.
  - An SCK edge in the timeout cycle takes priority and clears the timeout.
- Counter widths:
  - Bit counter is 4 bits, saturating at 8.
  - Timeout counter is $clog2(TIMEOUT_CYCLES) bits and does not wrap.

Decomposition:
- Shared package u62_pkg:
  - CMD_* codes, so the top level and other blocks share them.
  - State enum encoding (IDLE=0, RX=1, TURN=2, TX=3).
- One natural sub-module: sync_edge_detect (SYNC_STAGES flops plus rise/fall pulses). Instantiate it for SCK; SDATA uses the sync output only.

Test Plan:
- Reset with SCK low and SDATA_IN toggling → all outputs 0, FP_COMMAND=8'h00, BUSY=0, SDATA_OE=0.
- SCK at 100 kHz sends 8'h80 with FP_STATUS=8'hA5 → CMD_VALID and CMD_PLAY pulse once. The bench samples SDATA_OUT on the next 8 SCK rises = 1,0,1,0,0,1,0,1, and SDATA_OE drops after the last bit.
- Back-to-back 8'h40 then 8'h55 with no idle gap → CMD_FF pulse, then CMD_UNKNOWN pulse. FP_COMMAND ends at 8'h55, and no FRAME_ERROR occurs.
- 5 command bits, then SCK held high for TIMEOUT_CYCLES → FRAME_ERROR single pulse, FP_COMMAND unchanged, BUSY=0. A following 8'h60 decodes as CMD_STOP.
- FP_STATUS changes from 8'h0F to 8'hF0 mid-TX → the bench still reads 8'h0F.
- RESET_n asserted during TX bit 3 → SDATA_OE=0 the next cycle, state IDLE. A subsequent 8'h08 yields CMD_IDLE.
